// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: issue, ALU/LSU result and RegFile write-port bundle; bypass signals exist only with RF_BYPASS_EN.
interface regfile_wb_arbiter_if #(parameter int WIDTH = 32, parameter int ADRESS_WIDTH = 5);
  logic issue_valid;
  logic [ADRESS_WIDTH-1:0] issue_rd, issue_rs1, issue_rs2;
  logic issue_stall;
  logic alu_valid;
  logic [ADRESS_WIDTH-1:0] alu_rd;
  logic [WIDTH-1:0] alu_data;
  logic lsu_valid, lsu_ready;
  logic [ADRESS_WIDTH-1:0] lsu_rd;
  logic [WIDTH-1:0] lsu_data;
  logic [ADRESS_WIDTH-1:0] wr_addr0;
  logic [WIDTH-1:0] wr_din0;
  logic we0;
`ifdef RF_BYPASS_EN
  logic [ADRESS_WIDTH-1:0] rd_addr0, rd_addr1;
  logic byp_hit0, byp_hit1;
  logic [WIDTH-1:0] byp_data0, byp_data1;
`endif
  modport master (
`ifdef RF_BYPASS_EN
    input rd_addr0, rd_addr1,
    output byp_hit0, byp_hit1, byp_data0, byp_data1,
`endif
    input issue_valid, issue_rd, issue_rs1, issue_rs2, alu_valid, alu_rd, alu_data,
    input lsu_valid, lsu_rd, lsu_data,
    output issue_stall, lsu_ready, wr_addr0, wr_din0, we0
  );
  modport slave (
`ifdef RF_BYPASS_EN
    output rd_addr0, rd_addr1,
    input byp_hit0, byp_hit1, byp_data0, byp_data1,
`endif
    output issue_valid, issue_rd, issue_rs1, issue_rs2, alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    input issue_stall, lsu_ready, wr_addr0, wr_din0, we0
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: merges ALU and buffered LSU results onto one RegFile write port with a RAW pending scoreboard; RF_BYPASS_EN adds read bypass.
module regfile_wb_arbiter #(
  parameter int WIDTH = 32,
  parameter int ADRESS_WIDTH = 5,
  parameter int DEPTH = 32,
  parameter int FIFO_DEPTH = 2
) (
  input logic clk,
  input logic rst,
  regfile_wb_arbiter_if.master bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  logic [ADRESS_WIDTH+WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic [DEPTH-1:0] pending, pending_nxt;
  logic full, push, pop, sel, we, clr1, clr2;
  logic [ADRESS_WIDTH-1:0] waddr;
  logic [WIDTH-1:0] wdata;
  // ALU always wins the port; the FIFO head only drains in ALU-idle cycles
  always_comb begin
    full = count == CW'(FIFO_DEPTH);
    bus.lsu_ready = !rst && !full;
    push = bus.lsu_valid && bus.lsu_ready;
    pop = !rst && !bus.alu_valid && count != '0;
    sel = !rst && (bus.alu_valid || pop);
    {waddr, wdata} = bus.alu_valid ? {bus.alu_rd, bus.alu_data} : mem[head];
    we = sel && waddr != '0;
    bus.wr_addr0 = waddr;
    bus.wr_din0 = wdata;
    bus.we0 = we;
`ifdef RF_BYPASS_EN
    clr1 = we && waddr == bus.issue_rs1;
    clr2 = we && waddr == bus.issue_rs2;
    bus.byp_hit0 = we && bus.rd_addr0 == waddr && bus.rd_addr0 != '0;
    bus.byp_hit1 = we && bus.rd_addr1 == waddr && bus.rd_addr1 != '0;
    bus.byp_data0 = wdata;
    bus.byp_data1 = wdata;
`else
    clr1 = 1'b0;
    clr2 = 1'b0;
`endif
    bus.issue_stall = (pending[bus.issue_rs1] && !clr1) || (pending[bus.issue_rs2] && !clr2);
  end
  // set after clear so a same-cycle issue to the written register stays pending
  always_comb begin
    pending_nxt = pending;
    if (sel) pending_nxt[waddr] = 1'b0;
    if (bus.issue_valid && bus.issue_rd != '0) pending_nxt[bus.issue_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      pending <= pending_nxt;
      head <= head + PW'(pop);
      tail <= tail + PW'(push);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= {bus.lsu_rd, bus.lsu_data};
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed steps; LSU results queued on acceptance and popped when the write port drains them.
module tb_regfile_wb_arbiter;
  localparam int W = 32;
  localparam int AW = 5;
  typedef struct packed {logic [AW-1:0] rd; logic [W-1:0] d;} ent_t;
  logic clk = 1'b0;
  logic rst;
  int n_chk = 0;
  int n_fail = 0;
  ent_t lsu_q[$];
  logic [31:0] pend = '0;
  always #5 clk = ~clk;
  regfile_wb_arbiter_if #(.WIDTH(W), .ADRESS_WIDTH(AW)) bus ();
  regfile_wb_arbiter #(.WIDTH(W), .ADRESS_WIDTH(AW), .DEPTH(32), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic idle();
    bus.issue_valid = 0; bus.issue_rd = 0; bus.issue_rs1 = 0; bus.issue_rs2 = 0;
    bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
    bus.lsu_valid = 0; bus.lsu_rd = 0; bus.lsu_data = 0;
`ifdef RF_BYPASS_EN
    bus.rd_addr0 = 3; bus.rd_addr1 = 7;
`endif
  endtask
  task automatic alu(input logic [AW-1:0] rd, input logic [W-1:0] d);
    bus.alu_valid = 1; bus.alu_rd = rd; bus.alu_data = d;
  endtask
  task automatic lsu(input logic [AW-1:0] rd, input logic [W-1:0] d);
    bus.lsu_valid = 1; bus.lsu_rd = rd; bus.lsu_data = d;
  endtask
  task automatic step();
    ent_t e;
    logic sel, we_e, rdy, c1, c2;
    logic [31:0] pn;
    @(negedge clk);
    rdy = !rst && lsu_q.size() < 2;
    sel = !rst && (bus.alu_valid || lsu_q.size() > 0);
    e = bus.alu_valid ? {bus.alu_rd, bus.alu_data} : (lsu_q.size() > 0 ? lsu_q[0] : '0);
    we_e = sel && e.rd != 0;
`ifdef RF_BYPASS_EN
    c1 = we_e && e.rd == bus.issue_rs1;
    c2 = we_e && e.rd == bus.issue_rs2;
    chk("byp_hit0", 32'(bus.byp_hit0), 32'(we_e && bus.rd_addr0 == e.rd && bus.rd_addr0 != 0));
    chk("byp_hit1", 32'(bus.byp_hit1), 32'(we_e && bus.rd_addr1 == e.rd && bus.rd_addr1 != 0));
    if (we_e) chk("byp_data0", bus.byp_data0, e.d);
`else
    c1 = 0;
    c2 = 0;
`endif
    chk("we0", 32'(bus.we0), 32'(we_e));
    chk("lsu_ready", 32'(bus.lsu_ready), 32'(rdy));
    chk("issue_stall", 32'(bus.issue_stall),
        32'((pend[bus.issue_rs1] && !c1) || (pend[bus.issue_rs2] && !c2)));
    if (we_e) begin
      chk("wr_addr0", 32'(bus.wr_addr0), 32'(e.rd));
      chk("wr_din0", bus.wr_din0, e.d);
    end
    if (sel && !bus.alu_valid) void'(lsu_q.pop_front());
    if (rdy && bus.lsu_valid) lsu_q.push_back({bus.lsu_rd, bus.lsu_data});
    pn = pend;
    if (sel) pn[e.rd] = 0;
    if (bus.issue_valid && bus.issue_rd != 0) pn[bus.issue_rd] = 1;
    pn[0] = 0;
    if (rst) begin
      pn = '0;
      lsu_q.delete();
    end
    @(posedge clk);
    pend = pn;
    #1;
  endtask
  initial begin
    idle();
    rst = 1;
    alu(5, 32'h1);
    step(); step();
    rst = 0; idle();
    bus.issue_rs1 = 5; bus.issue_rs2 = 9;
    step();
    idle(); alu(5, 32'hDEAD_BEEF);
    step();
    for (int i = 0; i < 3; i++) begin
      idle(); alu(3, 32'h300 + 32'(i)); lsu(7, 32'h700 + 32'(i));
      step();
    end
    idle();
    step(); step(); step();
    bus.issue_valid = 1; bus.issue_rd = 9;
    step();
    idle(); bus.issue_rs1 = 9;
    step(); step();
    lsu(9, 32'h99);
    step();
    idle(); bus.issue_rs1 = 9;
    step(); step();
    idle(); alu(0, 32'h1);
    step();
    idle(); bus.issue_valid = 1; bus.issue_rd = 0;
    step();
    idle(); bus.issue_rs1 = 0;
    step();
    bus.issue_valid = 1; bus.issue_rd = 12;
    step();
    idle(); bus.issue_rs2 = 12;
    step();
    alu(12, 32'hC0C0);
    step();
    idle(); bus.issue_rs2 = 12;
    step();
    idle(); bus.issue_valid = 1; bus.issue_rd = 4; alu(4, 32'h44);
    step();
    idle(); bus.issue_rs1 = 4;
    step();
    alu(4, 32'h45);
    step();
    idle(); bus.issue_rs1 = 4;
    step();
    idle(); bus.issue_valid = 1; bus.issue_rd = 10;
    step();
    for (int i = 0; i < 2; i++) begin
      idle(); alu(2, 32'h200 + 32'(i)); lsu(11, 32'hB00 + 32'(i));
      step();
    end
    idle(); rst = 1; alu(6, 32'h66);
    step();
    rst = 0; idle(); bus.issue_rs1 = 10;
    step(); step();
    idle(); lsu(13, 32'hD0);
    step();
    idle();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
